// File: rtl/framing_ctrl.sv
// Circular-buffer frame controller: writes the sample stream into framing_memory and
// replays each full frame oldest-first. Optional pre-emphasis via `FRAMING_PREEMPH_EN.
module framing_ctrl #(
  parameter int BITS  = 12,
  parameter int DEPTH = 128,
  parameter int HOP   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            mem_wen,
  output logic [$clog2(DEPTH)-1:0] mem_a,
  output logic [BITS-1:0] mem_d,
  input  logic [BITS-1:0] mem_q
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   THR_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THR_HOP  = (AW+1)'(HOP);

  typedef enum logic {FILL, STREAM} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [AW-1:0] rd_cnt, rd_cnt_nxt;
  logic [AW:0]   new_cnt, new_cnt_nxt;
  logic [AW:0]   cnt_inc;
  logic          primed, primed_nxt;
  logic          accept;
  logic [BITS-1:0] sample_w;

  // Write port is gated by rst_n so nothing is written while reset is held.
  assign accept = (state == FILL) && in_valid && rst_n;

`ifdef FRAMING_PREEMPH_EN
  logic [BITS-1:0]        prev_q;
  logic signed [BITS+1:0] x_ext, p_ext, diff;

  always_comb begin
    x_ext = {{2{in_data[BITS-1]}}, in_data};
    p_ext = {{2{prev_q[BITS-1]}}, prev_q};
    diff  = x_ext - (p_ext - (p_ext >>> 5));
    // Three top bits equal means the result already fits in BITS.
    if ((diff[BITS+1:BITS-1] == 3'b000) || (diff[BITS+1:BITS-1] == 3'b111))
      sample_w = diff[BITS-1:0];
    else if (diff[BITS+1])
      sample_w = {1'b1, {(BITS-1){1'b0}}};
    else
      sample_w = {1'b0, {(BITS-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev_q <= '0;
    else if (accept)
      prev_q <= in_data;
  end
`else
  assign sample_w = in_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_cnt  <= '0;
      new_cnt <= '0;
      primed  <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_cnt  <= rd_cnt_nxt;
      new_cnt <= new_cnt_nxt;
      primed  <= primed_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    rd_cnt_nxt  = rd_cnt;
    new_cnt_nxt = new_cnt;
    primed_nxt  = primed;
    cnt_inc     = new_cnt + 1'b1;
    in_ready    = (state == FILL);
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    mem_wen     = 1'b0;
    mem_a       = wr_ptr;
    mem_d       = '0;

    case (state)
      FILL: begin
        if (accept) begin
          mem_wen     = 1'b1;
          mem_d       = sample_w;
          wr_ptr_nxt  = wr_ptr + 1'b1;
          new_cnt_nxt = cnt_inc;
          // The first frame needs a full buffer; later frames only HOP new samples.
          if (cnt_inc == (primed ? THR_HOP : THR_FULL)) begin
            state_nxt   = STREAM;
            new_cnt_nxt = '0;
            primed_nxt  = 1'b1;
            rd_ptr_nxt  = wr_ptr + 1'b1;
            rd_cnt_nxt  = '0;
          end
        end
      end
      STREAM: begin
        mem_a     = rd_ptr;
        out_valid = 1'b1;
        out_data  = mem_q;
        out_last  = (rd_cnt == LAST_IDX);
        if (out_ready) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          rd_cnt_nxt = rd_cnt + 1'b1;
          if (rd_cnt == LAST_IDX)
            state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

endmodule

// File: doc/framing_ctrl.md
# framing_ctrl

Frame controller in front of `framing_memory`, the 128×12 register-file buffer in the MFCC front end. Accepts the audio sample stream and writes it into the memory as a circular buffer. Once enough new samples have arrived, it reads one full frame back out, oldest sample first, as a valid/ready stream toward the windowing stage. It is the sole master of the memory's `wen`/`a`/`d` port and consumes its combinational `out`.

## Interface
- `BITS`, 12 — sample width, two's complement.
- `DEPTH`, 128 — frame length and memory depth; power of two. `AW = $clog2(DEPTH)`, 7 at default.
- `HOP`, 64 — new samples between consecutive frames; 1 ≤ HOP ≤ DEPTH.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `in_valid` in 1 — input sample valid.
- `in_data` in BITS — input sample.
- `in_ready` out 1 — controller can accept a sample.
- `out_valid` out 1 — frame sample valid.
- `out_data` out BITS — frame sample.
- `out_last` out 1 — marks sample DEPTH-1 of the frame.
- `out_ready` in 1 — downstream accepts.
- `mem_wen` out 1 — memory write enable (1 = write).
- `mem_a` out AW — memory address.
- `mem_d` out BITS — memory write data.
- `mem_q` in BITS — memory read data; combinational from `mem_a`.

## Operation
- State `FILL`:
  - `in_ready` = 1.
  - An accept is `in_valid & in_ready`. On accept, `mem_wen` = 1, `mem_a` = `wr_ptr`, `mem_d` = processed sample (see Configuration). These outputs are combinational.
  - Each accept increments `wr_ptr` (AW bits, wraps DEPTH-1 → 0) and `new_cnt` (AW+1 bits).
  - The frame threshold is DEPTH while `primed` = 0, and HOP once `primed` = 1.
  - When an accept makes `new_cnt` equal the threshold: go to `STREAM`, set `new_cnt` = 0, `primed` = 1, `rd_ptr` = post-increment `wr_ptr` (the oldest sample), `rd_cnt` = 0.
- State `STREAM`:
  - `in_ready` = 0; `in_valid` is ignored and no write occurs.
  - `mem_wen` = 0, `mem_a` = `rd_ptr`, `out_valid` = 1, `out_data` = `mem_q`.
  - `out_last` = (`rd_cnt` == DEPTH-1).
  - On `out_valid & out_ready`: `rd_ptr` increments (wrapping), `rd_cnt` increments.
  - The handshake with `out_last` = 1 returns the state to `FILL`.
- Outside an accept in `FILL`: `mem_wen` = 0, `mem_a` = `wr_ptr`, `mem_d` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0.
- `out_data`/`out_last` must hold stable while `out_valid & !out_ready`.
- Reset (any time, including mid-stream):
  - State `FILL`; `wr_ptr`, `rd_ptr`, `new_cnt`, `rd_cnt` = 0; `primed` = 0.
  - Output values during reset: `in_ready` = 1, `out_valid` = 0, `out_last` = 0, `mem_wen` = 0, `mem_a` = 0.
  - A partial frame is discarded. The next frame again requires DEPTH samples.
  - Memory contents are cleared by the memory's own reset on the same `rst_n`.

## Timing
- Write latency: a sample accepted at edge N is stored at edge N and readable in cycle N+1.
- Frame start: the threshold accept at edge N gives `STREAM` with `out_valid` = 1 in cycle N+1.
- Frame duration: with `out_ready` held high, exactly DEPTH cycles (N+1 … N+DEPTH); `out_last` is high in cycle N+DEPTH.
- Return to fill: after the `out_last` handshake at edge M, `in_ready` = 1 in cycle M+1.
- Steady-state period is at least HOP + DEPTH cycles per frame. Upstream absorbs back-pressure.
- There are no bubbles inside a frame other than those caused by `out_ready` = 0.

## Configuration
- `FRAMING_PREEMPH_EN` defined: pre-emphasis is applied before the write.
  - y = x − (p − (p >>> 5)), where p is the previous accepted raw sample.
  - Computed at BITS+2 signed, then saturated to [−2^(BITS−1), 2^(BITS−1)−1].
  - p is a BITS register updated on each accept; reset 0.
- `FRAMING_PREEMPH_EN` undefined: `mem_d` = `in_data` on accept, and no p register exists.

## Test plan
- Reset check: `rst_n` low → `in_ready` = 1, `out_valid` = 0, `mem_wen` = 0, `mem_a` = 0.
- First frame: feed 0..127 continuously with `out_ready` = 1 → `out_valid` rises the cycle after sample 127 is accepted; outputs 0..127 on 128 consecutive cycles; `out_last` only with 127.
- Second frame: feed 128..191 → frame is 64..191; `rd_ptr` wraps 127 → 0 at value 127→128.
- Back-pressure: in the first frame, hold `out_ready` = 0 for 5 cycles while `out_data` = 10 → `out_data` stays 10 and `in_valid` pulses produce no `mem_wen`; the frame completes with all 128 values in order.
- Mid-stream reset: assert `rst_n` low at sample 40 of a frame → state `FILL`, `primed` = 0; the next `out_valid` appears only after 128 new samples.
- With `FRAMING_PREEMPH_EN`:
  - Input 2047 after reset → `mem_d` = 2047.
  - Then −2048 → intermediate −4032 saturates to `mem_d` = −2048.
  - Then 32 → 32 − (−2048 + 64) = 2016.
